// File: rtl/sync_sram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM.
package sync_sram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    // Bit that makes the total number of ones in {byte, bit} even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_sram_if.sv
// Request/response bus of sync_sram; par_inject exists only when SYNC_SRAM_PARITY_EN is defined.
interface sync_sram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) ();

    localparam int BE_W = sync_sram_pkg::byte_lanes(DATA_W);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              init_done;
`ifdef SYNC_SRAM_PARITY_EN
    logic              par_inject;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
`ifdef SYNC_SRAM_PARITY_EN
        output par_inject,
`endif
        input  req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
`ifdef SYNC_SRAM_PARITY_EN
        input  par_inject,
`endif
        output req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

endinterface

// File: rtl/sync_sram_bank.sv
// Storage array with byte-lane writes and a registered read port returning the post-write word.
// Optional per-byte even parity when SYNC_SRAM_PARITY_EN is defined.
module sync_sram_bank import sync_sram_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic                          upd,
    input  logic [AW-1:0]                 addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [byte_lanes(DATA_W)-1:0] be,
`ifdef SYNC_SRAM_PARITY_EN
    input  logic                          inj,
`endif
    output logic [DATA_W-1:0]             rdata,
    output logic                          perr
);

    localparam int NB = byte_lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] word_nxt;
    logic              perr_nxt;

    // Response always shows the word as it stands after this cycle's write.
    always_comb begin
        word_nxt = mem[addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                word_nxt[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

`ifdef SYNC_SRAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] par_nxt;

    always_comb begin
        par_nxt  = par[addr];
        perr_nxt = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (we && be[i]) begin
                par_nxt[i] = even_parity(wdata[8*i +: 8]) ^ inj;
            end
            if (par_nxt[i] != even_parity(word_nxt[8*i +: 8])) begin
                perr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            par[addr] <= par_nxt;
        end
    end
`else
    assign perr_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            perr  <= 1'b0;
        end else if (upd) begin
            rdata <= word_nxt;
            perr  <= perr_nxt;
        end
    end

endmodule

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM: zero-initialises after reset, then serves one request per cycle
// with a fixed one-cycle response. Parity storage is enabled with SYNC_SRAM_PARITY_EN.
module sync_sram import sync_sram_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024
) (
    input  logic           Clk,
    input  logic           Reset_n,
    sync_sram_if.slave     bus
);

    localparam int NB = byte_lanes(DATA_W);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   LAST      = AW'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready, done, accept, in_range;
    logic              resp_valid_q, oor_q;
    logic              bank_we, bank_upd;
    logic [AW-1:0]     bank_addr;
    logic [DATA_W-1:0] bank_wdata, bank_rdata;
    logic [NB-1:0]     bank_be;
    logic              bank_perr;
`ifdef SYNC_SRAM_PARITY_EN
    logic              bank_inj;
`endif

    // Extra top bit keeps DEPTH == 2**ADDR_W from wrapping to zero.
    assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
    assign accept   = bus.req_valid & ready;
    assign bank_upd = accept & in_range;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready      = 1'b0;
        done       = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = bus.req_addr[AW-1:0];
        bank_wdata = bus.req_wdata;
        bank_be    = bus.req_be;
`ifdef SYNC_SRAM_PARITY_EN
        bank_inj   = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                bank_we    = 1'b1;
                bank_addr  = cnt_q;
                bank_wdata = '0;
                bank_be    = '1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready   = 1'b1;
                done    = 1'b1;
                bank_we = bus.req_valid & bus.req_write & in_range;
`ifdef SYNC_SRAM_PARITY_EN
                bank_inj = bus.par_inject;
`endif
            end
        endcase
    end

    sync_sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_bank (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (bank_we),
        .upd   (bank_upd),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .be    (bank_be),
`ifdef SYNC_SRAM_PARITY_EN
        .inj   (bank_inj),
`endif
        .rdata (bank_rdata),
        .perr  (bank_perr)
    );

    // oor_q only moves on accepts, so rdata/err hold while resp_valid is low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            resp_valid_q <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                oor_q <= ~in_range;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.init_done  = done;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = oor_q ? '0 : bank_rdata;
    assign bus.resp_err   = oor_q | bank_perr;

endmodule
